// File: rtl/redundancy_mode_controller.sv
// Sequences independent/DMR/TMR mode changes across lockstep channels: blocks all
// handshakes, waits for the redundancy modules to drain, commits, then fuses handshakes.
`timescale 1ns/1ps

module redundancy_mode_controller #(
   parameter int unsigned NumChannels   = 3,
   parameter int unsigned TimeoutCycles = 256,
   parameter logic [1:0]  ResetMode     = 2'b00
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic [1:0]             mode_i,
   output logic [1:0]             mode_o,
   output logic                   busy_o,
   output logic                   error_o,
   input  logic [NumChannels-1:0] busy_i,
   input  logic [NumChannels-1:0] valid_i,
   output logic [NumChannels-1:0] ready_o,
   output logic [NumChannels-1:0] valid_o,
   input  logic [NumChannels-1:0] ready_i
);

   localparam logic [1:0] MODE_DMR  = 2'b01;
   localparam logic [1:0] MODE_TMR  = 2'b10;
   localparam logic [1:0] MODE_RSVD = 2'b11;

   localparam int unsigned     CntW   = $clog2(TimeoutCycles);
   localparam logic [CntW-1:0] CntMax = CntW'(TimeoutCycles - 1);

   if (NumChannels < 3) begin : g_bad_channels
      $error("NumChannels must be >= 3");
   end
   if (TimeoutCycles < 2) begin : g_bad_timeout
      $error("TimeoutCycles must be >= 2");
   end
   if (ResetMode == MODE_RSVD) begin : g_bad_reset_mode
      $error("ResetMode must be a legal mode");
   end

   typedef enum logic [1:0] {
      RUN,
      WAIT_IDLE,
      COMMIT
   } state_e;

   state_e                   state_q, state_d;
   logic [1:0]               mode_q, mode_d;
   logic [1:0]               target_q, target_d;
   logic                     error_q, error_d;
   logic [CntW-1:0]          cnt_q, cnt_d;
   logic                     req_legal;
   logic                     set_error;
   logic                     blocked;
   logic [NumChannels-1:0]   grp_mask;

   assign req_legal = (mode_i != MODE_RSVD) && (mode_i != mode_q);

   // NOTE: every variable gets a default before the case, so no path can infer a latch.
   always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      target_d  = target_q;
      error_d   = error_q;
      cnt_d     = cnt_q;
      set_error = 1'b0;
      case (state_q)
         RUN: begin
            if (req_legal) begin
               target_d = mode_i;
               cnt_d    = '0;
               state_d  = WAIT_IDLE;
            end
         end
         WAIT_IDLE: begin
            if (req_legal) target_d = mode_i;
            if (mode_i == mode_q) begin
               state_d = RUN;
            end else if (busy_i == '0) begin
               state_d = COMMIT;
            end else begin
               if (cnt_q != CntMax) cnt_d = cnt_q + CntW'(1);
               if (cnt_q == CntMax) begin
                  set_error = 1'b1;
                  error_d   = 1'b1;
               end
            end
         end
         COMMIT: begin
            mode_d  = target_q;
            error_d = 1'b0;
            state_d = RUN;
         end
         default: state_d = RUN;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= RUN;
         mode_q   <= ResetMode;
         target_q <= ResetMode;
         error_q  <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         mode_q   <= mode_d;
         target_q <= target_d;
         error_q  <= error_d;
         cnt_q    <= cnt_d;
      end
   end

   // The request term makes blocking effective in the very cycle a request appears.
   assign blocked = (state_q != RUN) || req_legal;
   assign busy_o  = blocked;
   assign mode_o  = mode_q;
   assign error_o = error_q | set_error;

   always_comb begin
      case (mode_q)
         MODE_DMR: grp_mask = NumChannels'(2'b11);
         MODE_TMR: grp_mask = NumChannels'(3'b111);
         default:  grp_mask = NumChannels'(1'b1);
      endcase
   end

   // Grouped channels mirror channel 0 downstream; only channel 0 sees the fused ready.
   always_comb begin
      valid_o = '0;
      ready_o = '0;
      if (!blocked) begin
         for (int i = 0; i < int'(NumChannels); i++) begin
            if (grp_mask[i]) begin
               valid_o[i] = valid_i[0];
            end else begin
               valid_o[i] = valid_i[i];
               ready_o[i] = ready_i[i];
            end
         end
         ready_o[0] = &(ready_i | ~grp_mask);
      end
   end

endmodule

// File: tb/tb_redundancy_mode_controller.sv
// Scoreboard bench for redundancy_mode_controller: a cycle model pushes expected
// outputs as stimulus is driven, a negedge monitor pops and compares them.
`timescale 1ns/1ps

module tb_redundancy_mode_controller;

   localparam int N       = 3;
   localparam int TIMEOUT = 4;

   logic          clk_i;
   logic          rst_ni;
   logic [1:0]    mode_i;
   logic [1:0]    mode_o;
   logic          busy_o;
   logic          error_o;
   logic [N-1:0]  busy_i;
   logic [N-1:0]  valid_i;
   logic [N-1:0]  ready_o;
   logic [N-1:0]  valid_o;
   logic [N-1:0]  ready_i;

   int n_tests = 0;
   int n_fail  = 0;

   redundancy_mode_controller #(
      .NumChannels   (N),
      .TimeoutCycles (TIMEOUT),
      .ResetMode     (2'b00)
   ) dut (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .mode_i  (mode_i),
      .mode_o  (mode_o),
      .busy_o  (busy_o),
      .error_o (error_o),
      .busy_i  (busy_i),
      .valid_i (valid_i),
      .ready_o (ready_o),
      .valid_o (valid_o),
      .ready_i (ready_i)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef enum int {M_RUN, M_WAIT, M_COMMIT} mstate_e;

   typedef struct packed {
      logic [1:0]   mode;
      logic         busy;
      logic         error;
      logic [N-1:0] valid;
      logic [N-1:0] ready;
   } exp_t;

   exp_t         sb[$];
   mstate_e      m_state;
   logic [1:0]   m_mode;
   logic [1:0]   m_target;
   bit           m_err;
   int           m_waits;
   logic [1:0]   cur_mode;
   logic [N-1:0] cur_busy, cur_valid, cur_ready;

   function automatic bit is_req(input logic [1:0] m);
      return (m != 2'b11) && (m != m_mode);
   endfunction

   task automatic model_reset();
      m_state  = M_RUN;
      m_mode   = 2'b00;
      m_target = 2'b00;
      m_err    = 1'b0;
      m_waits  = 0;
   endtask

   // Applies one rising edge using the inputs held during the previous cycle.
   task automatic model_advance();
      case (m_state)
         M_RUN: begin
            if (is_req(cur_mode)) begin
               m_target = cur_mode;
               m_waits  = 0;
               m_state  = M_WAIT;
            end
         end
         M_WAIT: begin
            if (is_req(cur_mode)) m_target = cur_mode;
            if (cur_mode == m_mode) m_state = M_RUN;
            else if (cur_busy == '0) m_state = M_COMMIT;
            else begin
               if (m_waits >= TIMEOUT - 1) m_err = 1'b1;
               m_waits++;
            end
         end
         default: begin
            m_mode  = m_target;
            m_err   = 1'b0;
            m_state = M_RUN;
         end
      endcase
   endtask

   function automatic exp_t model_expect();
      exp_t e;
      int   k;
      bit   blk;
      blk     = (m_state != M_RUN) || is_req(cur_mode);
      e.mode  = m_mode;
      e.busy  = blk;
      e.error = m_err || (m_state == M_WAIT && cur_mode != m_mode &&
                          cur_busy != '0 && m_waits >= TIMEOUT - 1);
      e.valid = '0;
      e.ready = '0;
      if (!blk) begin
         k = (m_mode == 2'b01) ? 2 : (m_mode == 2'b10) ? 3 : 1;
         e.ready[0] = 1'b1;
         for (int i = 0; i < N; i++) begin
            if (i < k) begin
               e.valid[i] = cur_valid[0];
               e.ready[0] = e.ready[0] & cur_ready[i];
            end else begin
               e.valid[i] = cur_valid[i];
               e.ready[i] = cur_ready[i];
            end
         end
      end
      return e;
   endfunction

   // ---------------- stimulus helpers ----------------
   function automatic logic [N-1:0] rnd();
      return N'($urandom_range(0, (1 << N) - 1));
   endfunction

   task automatic drive(input logic [1:0] m, input logic [N-1:0] b,
                        input logic [N-1:0] v, input logic [N-1:0] r);
      mode_i    = m;
      busy_i    = b;
      valid_i   = v;
      ready_i   = r;
      cur_mode  = m;
      cur_busy  = b;
      cur_valid = v;
      cur_ready = r;
   endtask

   task automatic cycle(input logic [1:0] m, input logic [N-1:0] b,
                        input logic [N-1:0] v, input logic [N-1:0] r);
      @(posedge clk_i);
      model_advance();
      #1;
      drive(m, b, v, r);
      sb.push_back(model_expect());
      @(negedge clk_i);
      #1;
   endtask

   always @(negedge clk_i) begin
      exp_t e;
      while (sb.size() != 0) begin
         e = sb.pop_front();
         check("sb_mode",  8'(mode_o),  8'(e.mode));
         check("sb_busy",  8'(busy_o),  8'(e.busy));
         check("sb_error", 8'(error_o), 8'(e.error));
         check("sb_valid", 8'(valid_o), 8'(e.valid));
         check("sb_ready", 8'(ready_o), 8'(e.ready));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   // ---------------- directed sequence ----------------
   initial begin
      rst_ni = 1'b0;
      drive(2'b00, '0, 3'b101, 3'b011);
      model_reset();
      #2;
      check("rst_mode",  8'(mode_o),  8'h00);
      check("rst_busy",  8'(busy_o),  8'h00);
      check("rst_error", 8'(error_o), 8'h00);
      check("rst_valid", 8'(valid_o), 8'h05);
      repeat (2) @(posedge clk_i);
      #2;
      rst_ni = 1'b1;

      // Independent mode pass-through with random traffic.
      for (int c = 0; c < 20; c++) cycle(2'b00, rnd(), rnd(), rnd());
      check("t1_mode", 8'(mode_o), 8'h00);

      // 00 -> 01 held off by a busy channel, then released.
      for (int c = 0; c < 5; c++) begin
         cycle(2'b01, 3'b010, rnd(), rnd());
         check("t3_busy",  8'(busy_o),  8'h01);
         check("t3_mode",  8'(mode_o),  8'h00);
         check("t3_valid", 8'(valid_o), 8'h00);
      end
      cycle(2'b01, 3'b000, rnd(), rnd());
      check("t3_rel_mode", 8'(mode_o), 8'h00);
      cycle(2'b01, 3'b000, rnd(), rnd());
      check("t3_commit_busy", 8'(busy_o), 8'h01);
      cycle(2'b01, 3'b000, 3'b100, 3'b111);
      check("t3_new_mode", 8'(mode_o),  8'h01);
      check("t3_valid_o",  8'(valid_o), 8'h04);
      check("t3_ready_o",  8'(ready_o), 8'h05);

      // 01 -> 10 with no busy: minimum latency and TMR fusion.
      cycle(2'b10, 3'b000, 3'b001, 3'b111);
      check("t2_c0_valid", 8'(valid_o), 8'h00);
      check("t2_c0_ready", 8'(ready_o), 8'h00);
      check("t2_c0_busy",  8'(busy_o),  8'h01);
      for (int c = 1; c < 3; c++) begin
         cycle(2'b10, 3'b000, 3'b001, 3'b111);
         check("t2_blocked", 8'(busy_o), 8'h01);
      end
      cycle(2'b10, 3'b000, 3'b001, 3'b111);
      check("t2_mode",  8'(mode_o),  8'h02);
      check("t2_busy",  8'(busy_o),  8'h00);
      check("t2_valid", 8'(valid_o), 8'h07);
      check("t2_ready", 8'(ready_o), 8'h01);
      cycle(2'b10, 3'b000, 3'b001, 3'b101);
      check("t2_ready_and", 8'(ready_o), 8'h00);

      // 10 -> 00 with busy stuck: drain timeout, then commit clears the flag.
      cycle(2'b00, 3'b111, rnd(), rnd());
      for (int w = 0; w < 6; w++) begin
         cycle(2'b00, 3'b111, rnd(), rnd());
         check("t4_error", 8'(error_o), (w >= TIMEOUT - 1) ? 8'h01 : 8'h00);
      end
      cycle(2'b00, 3'b000, rnd(), rnd());
      cycle(2'b00, 3'b000, rnd(), rnd());
      check("t4_commit_err", 8'(error_o), 8'h01);
      cycle(2'b00, 3'b000, rnd(), rnd());
      check("t4_mode",  8'(mode_o),  8'h00);
      check("t4_error_clr", 8'(error_o), 8'h00);

      // Latest request wins, reserved value ignored.
      cycle(2'b01, 3'b111, rnd(), rnd());
      cycle(2'b10, 3'b111, rnd(), rnd());
      cycle(2'b11, 3'b111, rnd(), rnd());
      check("t5_rsvd_busy", 8'(busy_o), 8'h01);
      cycle(2'b11, 3'b000, rnd(), rnd());
      cycle(2'b11, 3'b000, rnd(), rnd());
      cycle(2'b11, 3'b000, rnd(), rnd());
      check("t5_target", 8'(mode_o), 8'h02);
      check("t5_idle",   8'(busy_o), 8'h00);

      // Abort after timeout, coinciding with busy falling: abort wins, error kept.
      cycle(2'b00, 3'b101, rnd(), rnd());
      for (int c = 0; c < 5; c++) cycle(2'b00, 3'b101, rnd(), rnd());
      cycle(2'b10, 3'b000, rnd(), rnd());
      cycle(2'b10, 3'b000, rnd(), rnd());
      check("t5_abort_busy",  8'(busy_o),  8'h00);
      check("t5_abort_mode",  8'(mode_o),  8'h02);
      check("t5_abort_error", 8'(error_o), 8'h01);
      for (int c = 0; c < 4; c++) cycle(2'b01, 3'b000, rnd(), rnd());
      check("t5_next_mode",  8'(mode_o),  8'h01);
      check("t5_next_error", 8'(error_o), 8'h00);

      // Asynchronous reset during WAIT_IDLE.
      cycle(2'b10, 3'b111, rnd(), rnd());
      cycle(2'b10, 3'b111, rnd(), rnd());
      check("t6w_pre_busy", 8'(busy_o), 8'h01);
      rst_ni = 1'b0;
      drive(2'b00, 3'b111, 3'b101, 3'b010);
      #1;
      check("t6w_mode",  8'(mode_o),  8'h00);
      check("t6w_busy",  8'(busy_o),  8'h00);
      check("t6w_error", 8'(error_o), 8'h00);
      check("t6w_valid", 8'(valid_o), 8'h05);
      check("t6w_ready", 8'(ready_o), 8'h02);
      @(posedge clk_i);
      #2;
      rst_ni = 1'b1;
      model_reset();

      // Asynchronous reset during COMMIT.
      cycle(2'b10, 3'b000, rnd(), rnd());
      cycle(2'b10, 3'b000, rnd(), rnd());
      cycle(2'b10, 3'b000, rnd(), rnd());
      check("t6c_pre_busy", 8'(busy_o), 8'h01);
      rst_ni = 1'b0;
      drive(2'b00, 3'b000, rnd(), rnd());
      #1;
      check("t6c_busy", 8'(busy_o), 8'h00);
      check("t6c_mode", 8'(mode_o), 8'h00);
      @(posedge clk_i);
      #1;
      check("t6c_no_commit", 8'(mode_o), 8'h00);
      #1;
      rst_ni = 1'b1;
      model_reset();
      for (int c = 0; c < 3; c++) cycle(2'b00, rnd(), rnd(), rnd());
      check("t6c_final_mode", 8'(mode_o), 8'h00);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/redundancy_mode_controller.md
Name: redundancy_mode_controller

Overview:
- Parametrised successor to the single-bit redundancy enable controller.
- Sequences transitions between independent, DMR and TMR modes across NumChannels lockstep-capable channels. Blocks all handshakes until the redundancy modules report idle, then commits the new mode.
- Fuses the grouped channel handshakes according to the committed mode.
- Adds a drain timeout with a sticky error flag.
- Sits between the upstream/downstream streams and the redundant cores/modules.

Parameters:
- NumChannels, 3, number of channels; must be >= 3 (elaboration assertion).
- TimeoutCycles, 256, number of WAIT_IDLE cycles before error_o asserts; must be >= 2.
- ResetMode, 2'b00, mode_o value after reset; must be a legal mode.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- mode_i  in  2  requested mode: 00 independent, 01 DMR, 10 TMR, 11 reserved
- mode_o  out  2  committed mode driven to the redundancy modules
- busy_o  out  1  a mode transition is pending or in progress
- error_o  out  1  sticky drain-timeout flag
- busy_i  in  NumChannels  per-channel busy from the redundancy modules
- valid_i  in  NumChannels  upstream valid
- ready_o  out  NumChannels  upstream ready
- valid_o  out  NumChannels  downstream valid
- ready_i  in  NumChannels  downstream ready

Behaviour:
- Reset values: state RUN, mode_o=ResetMode, target=ResetMode, error_o=0, counter=0.
- Outputs after reset: busy_o=0, valid_o/ready_o follow RUN rules.
- Reset is asynchronous and may occur mid-transition: it aborts the transition and mode_o returns to ResetMode.
- A request is legal when mode_i != 2'b11 and mode_i != mode_o.
- Reserved value 11 is ignored: it never starts a transition and never changes target.
- blocked = (state != RUN) or (state == RUN and a legal request is present).
  - The request term is combinational, so blocking takes effect in the same cycle the request appears.
- While blocked: valid_o=0 and ready_o=0 on all channels; busy_o=1.
- RUN:
  - With no legal request: pass handshakes per mode_o.
  - With a legal request: target<=mode_i, counter<=0, go to WAIT_IDLE.
- WAIT_IDLE:
  - Each cycle, if mode_i is legal then target<=mode_i (latest request wins).
  - If mode_i == mode_o, abort back to RUN; mode_o is unchanged and error_o is unchanged.
  - Else if busy_i == 0 (all channels), go to COMMIT.
  - Else counter increments, saturating at TimeoutCycles-1.
  - When counter == TimeoutCycles-1 and busy_i != 0, set error_o=1 and keep waiting.
- COMMIT: mode_o<=target, error_o<=0, go to RUN. Handshakes stay blocked during this cycle.
- Minimum latency, request to unblocked: request cycle, WAIT_IDLE, COMMIT, then RUN in the 3rd cycle after the request.
- The new mode is visible on mode_o from the first RUN cycle.
- Handshake mapping in RUN, with k the number of grouped channels (1 for independent, 2 for DMR, 3 for TMR):
  - Independent: valid_o[i]=valid_i[i], ready_o[i]=ready_i[i] for all i.
  - DMR/TMR grouped channels 0..k-1: valid_o[j]=valid_i[0] for all j<k.
  - ready_o[0]=AND of ready_i[0..k-1]; ready_o[1..k-1]=0; valid_i[1..k-1] are ignored.
  - Channels k..NumChannels-1 always pass through.
- Simultaneous cases:
  - busy_i falls in the same cycle as a new target: commit the updated target.
  - mode_i returns to mode_o in the same cycle busy_i falls: abort wins, and there is no COMMIT.

Test Plan:
1. Reset with ResetMode=00, mode_i=00, random valid/ready for 20 cycles -> mode_o=00, busy_o=0, valid_o==valid_i, ready_o==ready_i every cycle.
2. mode_i=10 with busy_i=0 -> cycle 0: valid_o=0, ready_o=0, busy_o=1. Cycles 0..2 stay blocked. Cycle 3: mode_o=10, busy_o=0. With valid_i=3'b001 and ready_i=3'b111: valid_o=3'b111, ready_o=3'b001. With ready_i=3'b101: ready_o=0.
3. From mode 00, mode_i=01 with busy_i=3'b010 held for 5 cycles -> blocked throughout, mode_o stays 00. Release busy_i -> mode_o=01 two cycles later; channel 2 passes through.
4. TimeoutCycles=4, busy_i held high -> error_o=1 from the 4th WAIT_IDLE cycle onwards and stays 1. Drop busy_i -> COMMIT clears error_o, and the new mode is committed.
5. In WAIT_IDLE, switch mode_i 01->10 and then 11 -> target=10, and 11 is ignored. Then set mode_i=mode_o -> return to RUN, mode_o unchanged, no COMMIT cycle.
6. Assert rst_ni in WAIT_IDLE and in COMMIT -> outputs immediately return to reset values (asynchronous), and no partial mode is committed.
